// File: rtl/fixed_point_pkg.sv
// Fixed-point types and helpers shared by the log2 / antilog feature stages.
// Q5.11 log2 codes (log_t) and unsigned Q16.16 linear values (fixed_t).
package fixed_point_pkg;

    localparam int LOG_WIDTH     = 16;
    localparam int FIX_WIDTH     = 32;
    localparam int LOG_FRAC_BITS = 11;
    localparam int FIX_FRAC_BITS = 16;
    localparam int LOG_INT_MIN   = -16;
    localparam int SHIFT_BIAS    = FIX_FRAC_BITS - LOG_FRAC_BITS;

    typedef logic signed [LOG_WIDTH-1:0] log_t;
    typedef logic        [FIX_WIDTH-1:0] fixed_t;

    typedef logic signed [5:0]             shift_t;
    typedef logic        [LOG_FRAC_BITS:0] mant_t;

    typedef struct packed {
        shift_t sh;
        mant_t  mant;
    } decode_t;

    function automatic decode_t antilog_decode(input log_t x);
        decode_t d;
        d.sh   = shift_t'($signed(x[LOG_WIDTH-1:LOG_FRAC_BITS])) + shift_t'(SHIFT_BIAS);
        d.mant = {1'b1, x[LOG_FRAC_BITS-1:0]};
        return d;
    endfunction

    // Negative shifts drop the low mantissa bits, truncating toward zero.
    function automatic fixed_t antilog_shift(input decode_t d);
        fixed_t wide;
        shift_t neg;
        wide = fixed_t'(d.mant);
        neg  = -d.sh;
        if (d.sh[5]) begin
            return wide >> neg;
        end
        return wide << d.sh;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One slot of an elastic valid/ready pipeline: loads when empty or when the
// downstream side drains it, otherwise holds its word stable.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/antilog.sv
// Q5.11 log2 -> Q16.16 linear converter, two-stage elastic pipeline.
// Optional macro ANTILOG_ZERO_FLOOR_EN maps the log-of-zero code 0x8000 to 0.
module antilog
    import fixed_point_pkg::*;
#(
    parameter int IN_FRAC   = 11,
    parameter int OUT_WIDTH = 32,
    parameter int OUT_FRAC  = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [15:0]          log_data_in,
    input  logic                 log_valid_in,
    output logic                 log_ready_out,
    output logic [OUT_WIDTH-1:0] exp_data_out,
    output logic                 exp_valid_out,
    input  logic                 exp_ready_in
);

    if (IN_FRAC != LOG_FRAC_BITS || OUT_WIDTH != FIX_WIDTH || OUT_FRAC != FIX_FRAC_BITS) begin : g_bad_params
        $error("antilog: only IN_FRAC=11, OUT_WIDTH=32, OUT_FRAC=16 are supported");
    end

    decode_t s1_d;
    decode_t s1_q;
    logic    s1_valid;
    logic    s2_ready;
    fixed_t  s2_d;

    always_comb begin
        s1_d = antilog_decode(log_t'(log_data_in));
`ifdef ANTILOG_ZERO_FLOOR_EN
        // An all-zero mantissa shifts to zero regardless of the exponent.
        if (log_data_in == 16'h8000) begin
            s1_d.mant = '0;
        end
`endif
    end

    pipe_stage #(.WIDTH($bits(decode_t))) u_decode (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .in_valid  (log_valid_in),
        .in_ready  (log_ready_out),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    assign s2_d = antilog_shift(s1_q);

    pipe_stage #(.WIDTH(OUT_WIDTH)) u_shift (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_d),
        .out_valid (exp_valid_out),
        .out_ready (exp_ready_in),
        .out_data  (exp_data_out)
    );

endmodule

// File: doc/antilog.md
Name: antilog

Overview:
- Inverse of the biometrics feature-extractor log2 stage.
- Converts a signed Q5.11 base-2 log value (5-bit signed integer part, 11-bit fraction) back to an unsigned Q16.16 linear value.
- Method: 2^int × (1 + frac), i.e. leading-one reconstruction plus linear interpolation.
- Two-stage elastic pipeline with valid/ready handshake on both sides. Used for feature denormalisation and for round-trip checking of the log stage.

Parameters:
- IN_FRAC, 11, fraction bits of log_data_in.
- OUT_WIDTH, 32, width of exp_data_out.
- OUT_FRAC, 16, fraction bits of exp_data_out.
- Only the defaults are supported and verified. Other values are elaboration-time errors.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- log_data_in  input  16  signed Q5.11 log2 value {int[4:0], frac[10:0]}.
- log_valid_in  input  1  upstream data valid.
- log_ready_out  output  1  block can accept a word this cycle.
- exp_data_out  output  32  unsigned Q16.16 result.
- exp_valid_out  output  1  result valid.
- exp_ready_in  input  1  downstream can accept.

Behaviour:
- Clock and reset:
  - One clock, clk_in. rst_in is synchronous, active-high.
  - Reset clears both stage valids, exp_valid_out=0 and exp_data_out=0. log_ready_out is 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight words. No partial output appears.
- Transfers: an input transfer occurs when log_valid_in && log_ready_out; an output transfer when exp_valid_out && exp_ready_in.
- Stage 1 (decode):
  - int = sign-extended log_data_in[15:11], range −16..15.
  - mant = {1'b1, log_data_in[10:0]}, 12 bits, Q1.11.
  - sh = int + (OUT_FRAC − IN_FRAC) = int + 5, signed, range −11..20.
  - Registers mant, sh and s1_valid.
- Stage 2 (shift):
  - sh ≥ 0: result = mant << sh. sh < 0: result = mant >> −sh, truncating.
  - Result is zero-extended to 32 bits and registered into exp_data_out / exp_valid_out.
  - Maximum sh=20 gives at most 0xFFF0_0000, so overflow is impossible and no saturation logic is needed.
- Latency: 2 cycles from input transfer to exp_valid_out with no backpressure. Throughput is 1 word per cycle.
- Elastic rules:
  - Stage 2 loads when !exp_valid_out || exp_ready_in.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - log_ready_out = !s1_valid || stage-2-load. This is combinational from exp_ready_in; there is no skid buffer.
- Stall: while exp_valid_out && !exp_ready_in, exp_data_out holds stable and no word is dropped or duplicated. With both stages full, log_ready_out=0.
- Simultaneous events: an output transfer and an input transfer in the same cycle both complete. Order is strictly preserved.
- Bubbles: when stage 1 is empty and stage 2 loads, exp_valid_out deasserts on the next edge unless new data arrives.
- Round-trip exactness: for any Q16.16 input x with at most 12 significant bits from its leading one, antilog(log(x)) = x.

Optional Feature:
- Macro: ANTILOG_ZERO_FLOOR_EN.
- Defined: input 0x8000 (int=−16, frac=0) is the log stage's code for zero and produces exp_data_out=0x0000_0000. Only 0x8000 is affected; 0x8001–0x87FF are unaffected.
- Not defined: 0x8000 produces 0x0000_0001 (2^−16). Handshake and timing are identical in both builds.

Decomposition:
- Shared package fixed_point_pkg holds:
  - typedef log_t (logic signed [15:0]) and typedef fixed_t (logic [31:0]).
  - Constants LOG_FRAC_BITS=11, FIX_FRAC_BITS=16, LOG_INT_MIN=−16.
  - This package is also to be adopted by the log stage.
- One natural sub-module, pipe_stage: a parameterised-width valid/ready register that handles load and hold. It is instantiated twice.

Test Plan:
- 0x0000 → 0x0001_0000. 0x0800 → 0x0002_0000. 0xF800 → 0x0000_8000. 0x0400 → 0x0001_8000. Each appears exactly 2 cycles after its transfer.
- 0x7FFF → 0xFFF0_0000 (max). 0x8400 → 0x0000_0001 (truncation). 0x8000 → 0x0000_0001 without the macro, 0x0000_0000 with ANTILOG_ZERO_FLOOR_EN.
- Back-to-back stream of 100 random words with exp_ready_in held high → one output per cycle, in order, matching the reference model.
- exp_ready_in held low for 5 cycles with 3 words offered → log_ready_out drops after 2 accepts, exp_data_out holds the first result, and all 3 emerge in order once ready returns.
- Random valid/ready toggling for 10k cycles → no loss, no duplication, and every stalled output is stable.
- rst_in asserted with both stages full → next cycle exp_valid_out=0, exp_data_out=0, log_ready_out=1, and no stale word ever appears.
